// File: rtl/strela_perf_ctr_bank_if.sv
// strela_perf_ctr_bank_if
//   Register-port bundle for the STRELA performance-counter bank.
//   master: drives the request (valid/write/addr/wdata), receives the response.
//   slave : receives the request, drives the one-cycle response strobe,
//           read data and unmapped-address error.
interface strela_perf_ctr_bank_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid_i;
    logic              req_write_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [31:0]       req_wdata_i;
    logic              rsp_valid_o;
    logic [31:0]       rsp_rdata_o;
    logic              rsp_error_o;

    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        input  rsp_valid_o, rsp_rdata_o, rsp_error_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        output rsp_valid_o, rsp_rdata_o, rsp_error_o
    );
endinterface

// File: rtl/strela_perf_ctr_bank.sv
// strela_perf_ctr_bank
//   NUM_CTRS performance counters of CTR_WIDTH bits, each with its own
//   enable, level/edge counting mode, saturate/wrap choice, sticky overflow
//   flag and interrupt enable. Counters are only observable through an
//   atomically loaded snapshot bank.
// Ports:
//   clk_i   - clock
//   rst_i   - asynchronous reset, active high
//   event_i - per-counter event level, synchronous to clk_i
//   bus     - register port (slave side), response registered one cycle later
//   irq_o   - registered OR of (ovf & irq_en)
module strela_perf_ctr_bank #(
    parameter int NUM_CTRS  = 8,
    parameter int CTR_WIDTH = 32,
    parameter int ADDR_W    = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_CTRS-1:0] event_i,
    strela_perf_ctr_bank_if.slave bus,
    output logic                irq_o
);
    localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

    logic                 gen;
    logic [NUM_CTRS-1:0]  en_mask;
    logic [NUM_CTRS-1:0]  edge_mask;
    logic [NUM_CTRS-1:0]  sat_mask;
    logic [NUM_CTRS-1:0]  ovf;
    logic [NUM_CTRS-1:0]  irq_en;
    logic [NUM_CTRS-1:0]  prev;
    logic [CTR_WIDTH-1:0] ctr  [NUM_CTRS];
    logic [CTR_WIDTH-1:0] snap [NUM_CTRS];

    logic [31:0]          addr;
    logic [31:0]          snap_idx;
    logic [63:0]          snap_sel;
    logic [31:0]          rd_data;
    logic                 dec_err;
    logic                 wr_csr;
    logic                 clr_pulse;
    logic                 snap_pulse;
    logic [NUM_CTRS-1:0]  ovf_w1c;
    logic [NUM_CTRS-1:0]  hit;
    logic [NUM_CTRS-1:0]  inc;
    logic [NUM_CTRS-1:0]  at_max;
    logic                 unused_bits;

    assign addr        = 32'(bus.req_addr_i);
    assign unused_bits = ^bus.req_wdata_i;

    // Address decode and read mux.
    always_comb begin
        rd_data  = '0;
        dec_err  = 1'b0;
        snap_idx = '0;
        snap_sel = '0;
        if (addr[1:0] != 2'b00) begin
            dec_err = 1'b1;
        end else if (addr < 32'h40) begin
            case (addr[5:2])
                4'd0:    rd_data = {31'd0, gen};
                4'd1:    rd_data = 32'(en_mask);
                4'd2:    rd_data = 32'(edge_mask);
                4'd3:    rd_data = 32'(sat_mask);
                4'd4:    rd_data = 32'(ovf);
                4'd5:    rd_data = 32'(irq_en);
                default: dec_err = 1'b1;
            endcase
        end else begin
            snap_idx = (addr - 32'h40) >> 3;
            for (int unsigned i = 0; i < NUM_CTRS; i++) begin
                if (snap_idx == i) snap_sel = 64'(snap[i]);
            end
            if (snap_idx >= 32'(NUM_CTRS) || bus.req_write_i) begin
                dec_err = 1'b1;
            end else begin
                rd_data = addr[2] ? snap_sel[63:32] : snap_sel[31:0];
            end
        end
    end

    always_comb begin
        wr_csr     = bus.req_valid_i & bus.req_write_i & ~dec_err;
        clr_pulse  = wr_csr && (addr[5:2] == 4'd0) && bus.req_wdata_i[1];
        snap_pulse = wr_csr && (addr[5:2] == 4'd0) && bus.req_wdata_i[2];
        ovf_w1c    = (wr_csr && (addr[5:2] == 4'd4)) ? bus.req_wdata_i[NUM_CTRS-1:0] : '0;
        // Edge-mode counters only hit on a rising event; prev tracks the raw event.
        hit        = event_i & ~(edge_mask & prev);
        inc        = {NUM_CTRS{gen}} & en_mask & hit;
        for (int unsigned i = 0; i < NUM_CTRS; i++) begin
            at_max[i] = (ctr[i] == CTR_MAX);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gen             <= 1'b0;
            en_mask         <= '0;
            edge_mask       <= '0;
            sat_mask        <= '0;
            ovf             <= '0;
            irq_en          <= '0;
            prev            <= '0;
            irq_o           <= 1'b0;
            bus.rsp_valid_o <= 1'b0;
            bus.rsp_rdata_o <= '0;
            bus.rsp_error_o <= 1'b0;
            for (int unsigned i = 0; i < NUM_CTRS; i++) begin
                ctr[i]  <= '0;
                snap[i] <= '0;
            end
        end else begin
            bus.rsp_valid_o <= bus.req_valid_i;
            bus.rsp_error_o <= bus.req_valid_i & dec_err;
            bus.rsp_rdata_o <= (bus.req_valid_i & ~bus.req_write_i & ~dec_err) ? rd_data : '0;

            prev  <= event_i;
            irq_o <= |(ovf & irq_en);
            // A fresh overflow beats a simultaneous write-1-to-clear.
            ovf   <= (ovf & ~ovf_w1c) | (inc & at_max);

            for (int unsigned i = 0; i < NUM_CTRS; i++) begin
                if (snap_pulse) snap[i] <= ctr[i];
                if (clr_pulse) begin
                    ctr[i] <= '0;
                end else if (inc[i]) begin
                    if (at_max[i]) ctr[i] <= sat_mask[i] ? CTR_MAX : '0;
                    else           ctr[i] <= ctr[i] + 1'b1;
                end
            end

            if (wr_csr) begin
                case (addr[5:2])
                    4'd0:    gen       <= bus.req_wdata_i[0];
                    4'd1:    en_mask   <= bus.req_wdata_i[NUM_CTRS-1:0];
                    4'd2:    edge_mask <= bus.req_wdata_i[NUM_CTRS-1:0];
                    4'd3:    sat_mask  <= bus.req_wdata_i[NUM_CTRS-1:0];
                    4'd5:    irq_en    <= bus.req_wdata_i[NUM_CTRS-1:0];
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_strela_perf_ctr_bank.sv
module tb_strela_perf_ctr_bank;
    localparam int NC   = 4;
    localparam int CW   = 4;
    localparam int AW   = 8;
    localparam int CMAX = (1 << CW) - 1;
    localparam int MASK = (1 << NC) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NC-1:0] ev  = '0;
    logic          irq;

    strela_perf_ctr_bank_if #(.ADDR_W(AW)) bus ();

    strela_perf_ctr_bank #(
        .NUM_CTRS (NC),
        .CTR_WIDTH(CW),
        .ADDR_W   (AW)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .event_i(ev),
        .bus    (bus),
        .irq_o  (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: counts held as plain integers, rules applied per cycle.
    int unsigned m_gen, m_en, m_edge, m_sat, m_ovf, m_irqen, m_prev;
    int unsigned m_ctr  [NC];
    int unsigned m_snap [NC];
    bit          m_irq;
    bit          e_valid, e_err;
    int unsigned e_rdata;
    logic [31:0] last_rdata;
    logic        last_err;

    function automatic void model_reset();
        m_gen = 0; m_en = 0; m_edge = 0; m_sat = 0; m_ovf = 0; m_irqen = 0; m_prev = 0;
        m_irq = 0; e_valid = 0; e_err = 0; e_rdata = 0;
        for (int i = 0; i < NC; i++) begin
            m_ctr[i]  = 0;
            m_snap[i] = 0;
        end
    endfunction

    function automatic void model_step(input int unsigned evv, input bit rv, input bit rw,
                                       input int unsigned ra, input int unsigned wd);
        int unsigned rdata = 0, inc = 0, setv = 0, w1c = 0, idx, nxt;
        bit err = 0, clr = 0, snp = 0;
        if (ra % 4 != 0) err = 1;
        else if (ra < 'h40) begin
            case (ra)
                'h00: rdata = m_gen;
                'h04: rdata = m_en;
                'h08: rdata = m_edge;
                'h0C: rdata = m_sat;
                'h10: rdata = m_ovf;
                'h14: rdata = m_irqen;
                default: err = 1;
            endcase
        end else begin
            idx = (ra - 'h40) / 8;
            if (idx >= NC || rw) err = 1;
            else rdata = (ra % 8 == 4) ? 0 : m_snap[idx];
        end
        e_valid = rv;
        e_err   = rv && err;
        e_rdata = (rv && !rw && !err) ? rdata : 0;

        for (int i = 0; i < NC; i++) begin
            bit lvl, was, h;
            lvl = (evv >> i) & 1;
            was = (m_prev >> i) & 1;
            h   = ((m_edge >> i) & 1) ? (lvl && !was) : lvl;
            if (m_gen != 0 && ((m_en >> i) & 1) != 0 && h) inc |= (1 << i);
        end
        m_irq = (m_ovf & m_irqen) != 0;

        if (rv && rw && !err && ra == 0) begin
            clr = wd[1];
            snp = wd[2];
        end
        for (int i = 0; i < NC; i++) begin
            if (snp) m_snap[i] = m_ctr[i];
            nxt = m_ctr[i];
            if ((inc >> i) & 1) begin
                if (m_ctr[i] == CMAX) setv |= (1 << i);
                nxt = m_ctr[i] + 1;
                if (nxt > CMAX) nxt = ((m_sat >> i) & 1) ? CMAX : 0;
            end
            m_ctr[i] = clr ? 0 : nxt;
        end
        if (rv && rw && !err) begin
            case (ra)
                'h00: m_gen   = wd & 1;
                'h04: m_en    = wd & MASK;
                'h08: m_edge  = wd & MASK;
                'h0C: m_sat   = wd & MASK;
                'h10: w1c     = wd & MASK;
                'h14: m_irqen = wd & MASK;
                default: ;
            endcase
        end
        m_ovf  = (m_ovf & ~w1c) | setv;
        m_prev = evv;
    endfunction

    task automatic tick();
        model_step(ev, bus.req_valid_i, bus.req_write_i, bus.req_addr_i, bus.req_wdata_i);
        @(posedge clk);
        #1;
        check_eq("rsp_valid", bus.rsp_valid_o, e_valid);
        if (e_valid) begin
            check_eq("rsp_error", bus.rsp_error_o, e_err);
            check_eq("rsp_rdata", bus.rsp_rdata_o, e_rdata);
        end
        check_eq("irq", irq, m_irq);
        last_rdata = bus.rsp_rdata_o;
        last_err   = bus.rsp_error_o;
        bus.req_valid_i = 1'b0;
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
    endtask

    task automatic access(input bit w, input int unsigned a, input int unsigned d);
        bus.req_valid_i = 1'b1;
        bus.req_write_i = w;
        bus.req_addr_i  = AW'(a);
        bus.req_wdata_i = d;
        tick();
    endtask

    task automatic wr(input int unsigned a, input int unsigned d);
        access(1'b1, a, d);
    endtask

    task automatic rd_chk(input string tag, input int unsigned a, input int unsigned exp);
        access(1'b0, a, 0);
        check_eq(tag, last_rdata, exp);
        check_eq({tag, "_err"}, last_err, 0);
    endtask

    task automatic edge_pattern();
        repeat (5) begin
            ev = 4'b0010; tick(); tick();
            ev = 4'b0000; tick(); tick();
        end
    endtask

    int unsigned reg_addrs [14] = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h14,
                                    'h40, 'h44, 'h48, 'h4C, 'h50, 'h54, 'h58, 'h5C};
    int unsigned rnd_addrs [16] = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h14, 'h3C, 'h60,
                                    'h40, 'h44, 'h48, 'h4C, 'h50, 'h54, 'h58, 'h5C};

    initial begin
        int unsigned a, d;
        bus.req_valid_i = 1'b0;
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rsp_valid", bus.rsp_valid_o, 0);
        check_eq("rst_irq", irq, 0);
        rst = 1'b0;
        tick();
        foreach (reg_addrs[k]) rd_chk("reset_read", reg_addrs[k], 0);
        access(1'b0, 'h3C, 0);
        check_eq("err_3c", last_err, 1);
        access(1'b0, 'h60, 0);
        check_eq("err_snap_oob", last_err, 1);
        access(1'b1, 'h40, 'h5);
        check_eq("err_ro_write", last_err, 1);

        // Level counting, enable mask
        wr('h04, 'h1);
        wr('h00, 'h1);
        rd_chk("ctrl_gen", 'h00, 1);
        ev = 4'b1111;
        repeat (10) tick();
        ev = '0;
        wr('h00, 'h5);
        rd_chk("snap0_level10", 'h40, 10);
        rd_chk("snap0_hi", 'h44, 0);
        rd_chk("snap1_disabled", 'h48, 0);

        // Edge vs level on counter 1
        wr('h00, 'h3);
        wr('h04, 'h2);
        wr('h08, 'h2);
        edge_pattern();
        wr('h00, 'h5);
        rd_chk("snap1_edge5", 'h48, 5);
        wr('h00, 'h3);
        wr('h08, 'h0);
        edge_pattern();
        wr('h00, 'h5);
        rd_chk("snap1_level10", 'h48, 10);

        // Wrap mode overflow
        wr('h04, 'h1);
        wr('h00, 'h3);
        ev = 4'b0001;
        repeat (17) tick();
        ev = '0;
        wr('h00, 'h5);
        rd_chk("wrap_snap", 'h40, 1);
        rd_chk("wrap_ovf", 'h10, 1);

        // Saturate mode overflow and interrupt
        wr('h10, 'hF);
        wr('h0C, 'h1);
        wr('h00, 'h3);
        ev = 4'b0001;
        repeat (17) tick();
        ev = '0;
        wr('h00, 'h5);
        rd_chk("sat_snap", 'h40, CMAX);
        rd_chk("sat_ovf", 'h10, 1);
        wr('h14, 'h1);
        check_eq("irq_not_yet", irq, 0);
        tick();
        check_eq("irq_set", irq, 1);
        wr('h10, 'h1);
        check_eq("irq_hold", irq, 1);
        tick();
        check_eq("irq_cleared", irq, 0);
        rd_chk("ovf_cleared", 'h10, 0);

        // CLR and SNAP together: snapshot takes pre-clear value
        wr('h00, 'h3);
        ev = 4'b0001;
        repeat (7) tick();
        wr('h00, 'h7);
        ev = '0;
        rd_chk("clr_snap_pre", 'h40, 7);
        wr('h00, 'h5);
        rd_chk("clr_snap_post", 'h40, 0);

        // Randomised traffic against the model
        wr('h04, 'hF);
        wr('h00, 'h1);
        repeat (800) begin
            ev = NC'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                a = rnd_addrs[$urandom_range(0, 15)];
                d = $urandom;
                if (a == 0) d = $urandom_range(0, 7) | (($urandom_range(0, 3) != 0) ? 1 : 0);
                access(1'(($urandom_range(0, 1))), a, d);
            end else begin
                tick();
            end
        end

        // Reset while a read response is pending, with counters running
        ev = '0;
        wr('h04, 'hF);
        wr('h00, 'h1);
        ev = 4'b1111;
        repeat (5) tick();
        ev = '0;
        bus.req_valid_i = 1'b1;
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = AW'('h10);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_pending_valid", bus.rsp_valid_o, 0);
        check_eq("rst_pending_irq", irq, 0);
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        @(posedge clk);
        #1;
        check_eq("rst_hold_valid", bus.rsp_valid_o, 0);
        rst = 1'b0;
        model_reset();
        tick();
        foreach (reg_addrs[k]) rd_chk("post_reset_read", reg_addrs[k], 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
